// File: rtl/line_raster_pkg.sv
// Shared render definitions for the line rasterizer and related walkers.
package line_raster_pkg;

  // Signed coordinate width for vertices and emitted pixels.
  localparam int COORD_W = 16;
  // Bresenham error term width and the width of its doubled value.
  localparam int ERR_W   = COORD_W + 2;
  localparam int E2_W    = COORD_W + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_e;

endpackage

// File: rtl/line_bres_step.sv
// One combinational Bresenham step: current pixel and error in, next pixel and error out.
module line_bres_step
  import line_raster_pkg::*;
(
  input  logic signed [COORD_W-1:0] cur_x_i,
  input  logic signed [COORD_W-1:0] cur_y_i,
  input  logic signed [ERR_W-1:0]   err_i,
  input  logic        [COORD_W:0]   dx_i,
  input  logic signed [ERR_W-1:0]   dy_i,
  input  logic                      sx_neg_i,
  input  logic                      sy_neg_i,
  output logic signed [COORD_W-1:0] next_x_o,
  output logic signed [COORD_W-1:0] next_y_o,
  output logic signed [ERR_W-1:0]   next_err_o
);

  localparam logic signed [COORD_W-1:0] ONE = {{(COORD_W-1){1'b0}}, 1'b1};

  logic signed [E2_W-1:0]    e2;
  logic signed [E2_W-1:0]    dy_ext;
  logic signed [E2_W-1:0]    dx_ext;
  logic signed [ERR_W-1:0]   dx_s;
  logic signed [ERR_W-1:0]   err_acc;
  logic signed [COORD_W-1:0] sx_val;
  logic signed [COORD_W-1:0] sy_val;
  logic                      step_x;
  logic                      step_y;

  // Compare doubled error against both deltas; both moves may fire (diagonal).
  always_comb begin
    e2      = {err_i, 1'b0};
    dy_ext  = {dy_i[ERR_W-1], dy_i};
    dx_ext  = {2'b00, dx_i};
    dx_s    = {1'b0, dx_i};
    sx_val  = sx_neg_i ? '1 : ONE;
    sy_val  = sy_neg_i ? '1 : ONE;
    step_x  = (e2 >= dy_ext);
    step_y  = (e2 <= dx_ext);
    err_acc = err_i;
    next_x_o = cur_x_i;
    next_y_o = cur_y_i;
    if (step_x) begin
      err_acc  = err_acc + dy_i;
      next_x_o = cur_x_i + sx_val;
    end
    if (step_y) begin
      err_acc  = err_acc + dx_s;
      next_y_o = cur_y_i + sy_val;
    end
    next_err_o = err_acc;
  end

endmodule

// File: rtl/line_raster.sv
// Sequential Bresenham line rasterizer: one segment command in, one pixel per cycle out.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload steady until that edge;
// ready may change freely. cmd_ready is high only in IDLE, pix_valid only in DRAW.
module line_raster
  import line_raster_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic signed [COORD_W-1:0] vtxA_X,
  input  logic signed [COORD_W-1:0] vtxA_Y,
  input  logic signed [COORD_W-1:0] vtxB_X,
  input  logic signed [COORD_W-1:0] vtxB_Y,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic signed [COORD_W-1:0] pix_X,
  output logic signed [COORD_W-1:0] pix_Y,
  output logic                      pix_last,
  output logic                      busy,
  output state_e                    dbg_state
);

  state_e state_q, state_d;

  logic signed [COORD_W-1:0] ax_q, ax_d, ay_q, ay_d;
  logic signed [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
  logic signed [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic        [COORD_W:0]   dx_q, dx_d;
  logic signed [ERR_W-1:0]   dy_q, dy_d, err_q, err_d;
  logic                      sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

  logic signed [COORD_W:0]   diff_x, diff_y;
  logic        [COORD_W:0]   setup_dx, abs_y;
  logic signed [ERR_W-1:0]   setup_dy, setup_err;

  logic signed [COORD_W-1:0] step_x, step_y;
  logic signed [ERR_W-1:0]   step_err;
  logic                      at_end;

  line_bres_step u_step (
    .cur_x_i   (cur_x_q),
    .cur_y_i   (cur_y_q),
    .err_i     (err_q),
    .dx_i      (dx_q),
    .dy_i      (dy_q),
    .sx_neg_i  (sx_neg_q),
    .sy_neg_i  (sy_neg_q),
    .next_x_o  (step_x),
    .next_y_o  (step_y),
    .next_err_o(step_err)
  );

  // Segment deltas from latched vertices, one bit wider than coordinates so the full range fits.
  always_comb begin
    diff_x    = {bx_q[COORD_W-1], bx_q} - {ax_q[COORD_W-1], ax_q};
    diff_y    = {by_q[COORD_W-1], by_q} - {ay_q[COORD_W-1], ay_q};
    setup_dx  = diff_x[COORD_W] ? (-diff_x) : diff_x;
    abs_y     = diff_y[COORD_W] ? (-diff_y) : diff_y;
    setup_dy  = -($signed({1'b0, abs_y}));
    setup_err = $signed({1'b0, setup_dx}) + setup_dy;
  end

  assign at_end    = (cur_x_q == bx_q) && (cur_y_q == by_q);
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign pix_valid = (state_q == DRAW);
  assign pix_last  = (state_q == DRAW) && at_end;
  assign pix_X     = cur_x_q;
  assign pix_Y     = cur_y_q;
  assign dbg_state = state_q;

  // Next-state and datapath update: latch in IDLE, derive deltas in SETUP, step in DRAW.
  always_comb begin
    state_d  = state_q;
    ax_d     = ax_q;
    ay_d     = ay_q;
    bx_d     = bx_q;
    by_d     = by_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          ax_d    = vtxA_X;
          ay_d    = vtxA_Y;
          bx_d    = vtxB_X;
          by_d    = vtxB_Y;
          state_d = SETUP;
        end
      end
      SETUP: begin
        dx_d     = setup_dx;
        dy_d     = setup_dy;
        err_d    = setup_err;
        sx_neg_d = !(ax_q < bx_q);
        sy_neg_d = !(ay_q < by_q);
        cur_x_d  = ax_q;
        cur_y_d  = ay_q;
        state_d  = DRAW;
      end
      DRAW: begin
        if (pix_ready) begin
          if (at_end) begin
            state_d = IDLE;
          end else begin
            cur_x_d = step_x;
            cur_y_d = step_y;
            err_d   = step_err;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously so a reset discards any segment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ax_q     <= '0;
      ay_q     <= '0;
      bx_q     <= '0;
      by_q     <= '0;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

endmodule

// File: tb/tb_line_raster.sv
// Directed bench for line_raster: timing, octants, backpressure, full range and reset.
module tb_line_raster;
  import line_raster_pkg::*;

  logic                      clk;
  logic                      rst;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic signed [COORD_W-1:0] vtxA_X, vtxA_Y, vtxB_X, vtxB_Y;
  logic                      pix_valid;
  logic                      pix_ready;
  logic signed [COORD_W-1:0] pix_X, pix_Y;
  logic                      pix_last;
  logic                      busy;
  state_e                    dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [2*COORD_W-1:0] exp_q[$];

  line_raster dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .vtxA_X   (vtxA_X),
    .vtxA_Y   (vtxA_Y),
    .vtxB_X   (vtxB_X),
    .vtxB_Y   (vtxB_Y),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_X    (pix_X),
    .pix_Y    (pix_Y),
    .pix_last (pix_last),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*COORD_W-1:0] pk(input int x, input int y);
    return {COORD_W'(x), COORD_W'(y)};
  endfunction

  // driver: present a command, wait for acceptance, then scramble the vertex inputs.
  // Returns at the falling edge inside the SETUP cycle.
  task automatic send_cmd(input int ax, input int ay, input int bx, input int by);
    int waited = 0;
    @(negedge clk);
    vtxA_X = COORD_W'(ax);
    vtxA_Y = COORD_W'(ay);
    vtxB_X = COORD_W'(bx);
    vtxB_Y = COORD_W'(by);
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_accept_timeout cmd_ready=%0b required=1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    vtxA_X = 16'sh1234;
    vtxA_Y = 16'sh4321;
    vtxB_X = 16'sh0F0F;
    vtxB_Y = 16'sh7070;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (cmd_ready !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0 || pix_last !== 1'b0 ||
        pix_X !== '0 || pix_Y !== '0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_hold cmd_ready=%0b pv=%0b busy=%0b last=%0b pix=(%0d,%0d) st=%0d required 0,0,0,0,(0,0),IDLE",
               cmd_ready, pix_valid, busy, pix_last, pix_X, pix_Y, dbg_state);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release cmd_ready=%0b busy=%0b required 1,0", cmd_ready, busy);
    end
  endtask

  task automatic test_shallow();
    int n;
    logic [2*COORD_W-1:0] e;
    exp_q = {};
    exp_q.push_back(pk(0, 0));
    exp_q.push_back(pk(1, 0));
    exp_q.push_back(pk(2, 1));
    exp_q.push_back(pk(3, 1));
    exp_q.push_back(pk(4, 2));
    exp_q.push_back(pk(5, 2));
    n = exp_q.size();
    send_cmd(0, 0, 5, 2);
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0 || dbg_state !== SETUP) begin
      failures++;
      $display("FAIL shallow_setup pv=%0b busy=%0b cmd_ready=%0b st=%0d required 0,1,0,SETUP",
               pix_valid, busy, cmd_ready, dbg_state);
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (pix_valid !== 1'b1 || {pix_X, pix_Y} !== e || pix_last !== (i == n - 1)) begin
        failures++;
        $display("FAIL shallow_pix%0d got v=%0b (%0d,%0d) last=%0b required v=1 (%0d,%0d) last=%0b",
                 i, pix_valid, pix_X, pix_Y, pix_last,
                 $signed(e[2*COORD_W-1:COORD_W]), $signed(e[COORD_W-1:0]), (i == n - 1));
      end
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL shallow_done cmd_ready=%0b pv=%0b busy=%0b required 1,0,0", cmd_ready, pix_valid, busy);
    end
  endtask

  task automatic test_degenerate();
    send_cmd(3, 7, 3, 7);
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b1 || pix_X !== 16'sd3 || pix_Y !== 16'sd7 || pix_last !== 1'b1) begin
      failures++;
      $display("FAIL degenerate_pix got v=%0b (%0d,%0d) last=%0b required v=1 (3,7) last=1",
               pix_valid, pix_X, pix_Y, pix_last);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL degenerate_done cmd_ready=%0b pv=%0b required 1,0", cmd_ready, pix_valid);
    end
  endtask

  task automatic test_steep_neg();
    int n;
    logic [2*COORD_W-1:0] e;
    exp_q = {};
    exp_q.push_back(pk(10, 10));
    exp_q.push_back(pk(9, 9));
    exp_q.push_back(pk(9, 8));
    exp_q.push_back(pk(8, 7));
    exp_q.push_back(pk(8, 6));
    exp_q.push_back(pk(7, 5));
    exp_q.push_back(pk(7, 4));
    n = exp_q.size();
    send_cmd(10, 10, 7, 4);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (pix_valid !== 1'b1 || {pix_X, pix_Y} !== e || pix_last !== (i == n - 1)) begin
        failures++;
        $display("FAIL steep_pix%0d got v=%0b (%0d,%0d) last=%0b required v=1 (%0d,%0d) last=%0b",
                 i, pix_valid, pix_X, pix_Y, pix_last,
                 $signed(e[2*COORD_W-1:COORD_W]), $signed(e[COORD_W-1:0]), (i == n - 1));
      end
    end
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL steep_done pv=%0b cmd_ready=%0b required 0,1", pix_valid, cmd_ready);
    end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    int k = 0;
    logic stalled = 1'b0;
    logic signed [COORD_W-1:0] hx, hy;
    logic hl;
    logic [2*COORD_W-1:0] e;
    hx = '0;
    hy = '0;
    hl = 1'b0;
    exp_q = {};
    for (int i = 0; i <= 4; i++) exp_q.push_back(pk(i, i));
    send_cmd(0, 0, 4, 4);
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_X !== hx || pix_Y !== hy || pix_last !== hl) begin
          failures++;
          $display("FAIL bp_stall_hold got v=%0b (%0d,%0d) last=%0b required v=1 (%0d,%0d) last=%0b",
                   pix_valid, pix_X, pix_Y, pix_last, hx, hy, hl);
        end
      end
      stalled = 1'b0;
      if (pix_valid === 1'b1) begin
        pix_ready = (k % 3 == 0);
        k++;
        if (pix_ready) begin
          e = exp_q.pop_front();
          hs++;
          checks++;
          if ({pix_X, pix_Y} !== e || pix_last !== (exp_q.size() == 0)) begin
            failures++;
            $display("FAIL bp_pix%0d got (%0d,%0d) last=%0b required (%0d,%0d) last=%0b",
                     hs - 1, pix_X, pix_Y, pix_last,
                     $signed(e[2*COORD_W-1:COORD_W]), $signed(e[COORD_W-1:0]), (exp_q.size() == 0));
          end
        end else begin
          stalled = 1'b1;
          hx = pix_X;
          hy = pix_Y;
          hl = pix_last;
        end
      end
    end
    @(negedge clk);
    pix_ready = 1'b1;
    checks++;
    if (hs != 5 || exp_q.size() != 0 || pix_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_count handshakes=%0d left=%0d pv=%0b cmd_ready=%0b required 5,0,0,1",
               hs, exp_q.size(), pix_valid, cmd_ready);
    end
  endtask

  task automatic test_full_range();
    int count = 0;
    int ychg = 0;
    int nonmono = 0;
    int gaps = 0;
    int px, py, prevx, prevy, fx, fy, lx, ly;
    logic done = 1'b0;
    prevx = 0; prevy = 0; fx = 0; fy = 0; lx = 0; ly = 0;
    send_cmd(-32768, -1, 32767, 0);
    for (int c = 0; c < 70000 && !done; c++) begin
      @(negedge clk);
      if (pix_valid === 1'b1) begin
        px = pix_X;
        py = pix_Y;
        if (count == 0) begin
          fx = px;
          fy = py;
        end else begin
          if (px != prevx + 1) nonmono++;
          if (py != prevy) ychg++;
        end
        if (pix_last === 1'b1) begin
          done = 1'b1;
          lx = px;
          ly = py;
        end
        count++;
        prevx = px;
        prevy = py;
      end else if (count > 0) begin
        gaps++;
      end
    end
    checks++;
    if (!done || count != 65536 || gaps != 0) begin
      failures++;
      $display("FAIL full_count done=%0b pixels=%0d gaps=%0d required 1,65536,0", done, count, gaps);
    end
    checks++;
    if (fx != -32768 || fy != -1 || lx != 32767 || ly != 0) begin
      failures++;
      $display("FAIL full_ends first=(%0d,%0d) last=(%0d,%0d) required (-32768,-1) (32767,0)", fx, fy, lx, ly);
    end
    checks++;
    if (nonmono != 0 || ychg != 1) begin
      failures++;
      $display("FAIL full_shape x_steps_bad=%0d y_changes=%0d required 0,1", nonmono, ychg);
    end
  endtask

  task automatic test_reset_mid();
    send_cmd(0, 0, 10, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (pix_valid !== 1'b1 || pix_X !== COORD_W'(i) || pix_Y !== '0) begin
        failures++;
        $display("FAIL rstmid_pix%0d got v=%0b (%0d,%0d) required v=1 (%0d,0)", i, pix_valid, pix_X, pix_Y, i);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 || pix_X !== '0 || pix_last !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async pv=%0b busy=%0b cmd_ready=%0b x=%0d last=%0b required 0,0,0,0,0",
               pix_valid, busy, cmd_ready, pix_X, pix_last);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || dbg_state !== IDLE || pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_idle cmd_ready=%0b st=%0d pv=%0b required 1,IDLE,0", cmd_ready, dbg_state, pix_valid);
    end
    send_cmd(1, 1, 2, 1);
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b1 || pix_X !== 16'sd1 || pix_Y !== 16'sd1 || pix_last !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_new0 got v=%0b (%0d,%0d) last=%0b required v=1 (1,1) last=0",
               pix_valid, pix_X, pix_Y, pix_last);
    end
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b1 || pix_X !== 16'sd2 || pix_Y !== 16'sd1 || pix_last !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_new1 got v=%0b (%0d,%0d) last=%0b required v=1 (2,1) last=1",
               pix_valid, pix_X, pix_Y, pix_last);
    end
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_new_done pv=%0b cmd_ready=%0b required 0,1", pix_valid, cmd_ready);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    pix_ready = 1'b1;
    vtxA_X    = '0;
    vtxA_Y    = '0;
    vtxB_X    = '0;
    vtxB_Y    = '0;
    test_reset();
    test_shallow();
    test_degenerate();
    test_steep_neg();
    test_backpressure();
    test_full_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_raster.md
# line_raster

Sequential line rasterizer for the render pipeline. It accepts a segment (vertex A, vertex B) over a valid/ready command handshake and emits the pixels of that segment, A first and B last, one per cycle over a valid/ready pixel stream. It uses integer Bresenham stepping in all octants. It is the producer counterpart of the per-pixel on-line test: where that test asks "is this scan position on AB", this block generates exactly the positions on AB for writing into the frame buffer.

## Interface
- COORD_W, default 16: signed coordinate width for vertices and output pixels.
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- cmd_valid  in  1  segment command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- vtxA_X, vtxA_Y  in  COORD_W  signed start vertex; sampled on command acceptance.
- vtxB_X, vtxB_Y  in  COORD_W  signed end vertex; sampled on command acceptance.
- pix_valid  out  1  pix_X/pix_Y hold a pixel.
- pix_ready  in  1  downstream accepts the pixel.
- pix_X, pix_Y  out  COORD_W  signed pixel coordinate.
- pix_last  out  1  qualifies the pixel equal to vertex B.
- busy  out  1  high in SETUP and DRAW.

## Operation
- States: IDLE, SETUP, DRAW.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch A and B, then go to SETUP.
- SETUP, one cycle:
  - dx=|Bx-Ax| (COORD_W+1 bits, unsigned).
  - dy=-|By-Ay| (COORD_W+2 signed).
  - sx=+1 if Ax<Bx, else -1.
  - sy=+1 if Ay<By, else -1.
  - err=dx+dy (COORD_W+2 signed).
  - Load the current pixel cur=A.
  - Go to DRAW.
- DRAW:
  - pix_valid=1, pix=cur, pix_last=(cur==B).
  - On handshake (pix_valid&pix_ready):
    - If pix_last, go to IDLE.
    - Otherwise step: e2=2*err (COORD_W+3 signed).
    - If e2>=dy: err+=dy, curX+=sx.
    - If e2<=dx: err+=dx, curY+=sy.
    - Both conditions may apply in the same step (diagonal move).
- Pixel count per segment = max(dx,|dy|)+1. There are no duplicates and no gaps, and each consecutive pair of pixels is 8-connected.
- Degenerate A==B: exactly one pixel, with pix_last=1.
- Horizontal and vertical segments: only one coordinate changes per step.
- Full signed range is supported, e.g. A=(-32768,0), B=(32767,0). All internal arithmetic is sized as above and must not overflow.
- Backpressure: while pix_valid&!pix_ready, pix_X, pix_Y, pix_last and the internal state hold unchanged.
- Commands arriving while busy wait, since cmd_ready=0. Vertex inputs are ignored outside the acceptance cycle.

## Timing
- Reset values, applied asynchronously:
  - state=IDLE.
  - cmd_ready=1 once rst deasserts; 0 while rst is high.
  - pix_valid=0, pix_last=0, busy=0.
  - pix_X=0, pix_Y=0, all internal registers 0.
- Acceptance at edge N. SETUP occupies cycle N+1. The first pixel, A, is valid in cycle N+2.
- With pix_ready held high, throughput is one pixel per cycle. A segment of K pixels completes its last handshake at edge N+1+K.
- After the last handshake, the block is in IDLE with cmd_ready=1 in the next cycle. Back-to-back segments therefore cost 2 idle pixel cycles (acceptance plus SETUP).
- pix_valid never drops between the first and last pixel of a segment unless rst is asserted.
- rst asserted mid-DRAW: outputs clear immediately and the segment is discarded. No partial resume after deassertion.
- All outputs are registered. There is no combinational path from pix_ready or cmd_valid to any output.

## Structure
- Shared render package holds:
  - COORD_W.
  - Derived widths ERR_W=COORD_W+2 and E2_W=COORD_W+3.
  - The state enum {IDLE, SETUP, DRAW}.
- One natural sub-module: line_bres_step, purely combinational. It maps (curX, curY, err, dx, dy, sx, sy) to (nextX, nextY, nextErr). It is unit-testable on its own and reusable by a later triangle edge walker.
- No memories; the block is roughly 10 registers wide per COORD_W.

## Test plan
- A=(0,0), B=(5,2), pix_ready=1:
  - Required pixels, in order: (0,0),(1,0),(2,1),(3,1),(4,2),(5,2).
  - pix_last only on (5,2).
  - First valid 2 cycles after acceptance.
- A=(3,7), B=(3,7) -> single pixel (3,7) with pix_last=1; cmd_ready=1 the cycle after the handshake.
- A=(10,10), B=(7,4), negative octant, steep:
  - Required: 7 pixels, Y decrementing every step, X decrementing on 3 of 6 steps.
  - Must end at (7,4).
- A=(0,0), B=(4,4) with pix_ready toggled 1,0,0,1,...:
  - Outputs stable on every stalled cycle.
  - Sequence (0,0)..(4,4) diagonal, exactly 5 handshakes.
- A=(-32768,-1), B=(32767,0):
  - Required: 65536 pixels, monotonic X, exactly one Y change.
  - No overflow; last pixel (32767,0).
- Mid-segment rst after 3 pixels:
  - pix_valid=0 asynchronously.
  - After deassertion the block is IDLE; a new command A=(1,1), B=(2,1) yields (1,1),(2,1) only.
